// File: rtl/modexp_ctrl.sv
// modexp_ctrl
//   Computes result = x^e mod M by left-to-right square-and-multiply. It drives
//   one shared Montgomery multiplier through a start/done handshake. Operands
//   are converted into the Montgomery domain first (Mont(x, R^2)) and back out
//   at the end (Mont(A, 1)).
// Ports
//   clk, resetn                 clock (rising edge), asynchronous active-low reset
//   start                       1-cycle request; all in_* operands sampled on that edge
//   in_x, in_e, in_e_len        base, exponent, number of exponent bits used
//   in_m, in_r_mod_m, in_r2_mod_m  odd modulus, R mod M, R^2 mod M (R = 2^N)
//   result, done, busy          final value (held), completion pulse, busy flag
//   mont_start/a/b/m            registered request to the multiplier
//   mont_result, mont_done      multiplier response, captured in the WAIT states
module modexp_ctrl #(
    parameter int N      = 1024,
    parameter int E_BITS = 1024,
    parameter int EL_W   = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N-1:0]      in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [EL_W-1:0]   in_e_len,
    input  logic [N-1:0]      in_m,
    input  logic [N-1:0]      in_r_mod_m,
    input  logic [N-1:0]      in_r2_mod_m,
    output logic [N-1:0]      result,
    output logic              done,
    output logic              busy,
    output logic              mont_start,
    output logic [N-1:0]      mont_a,
    output logic [N-1:0]      mont_b,
    output logic [N-1:0]      mont_m,
    input  logic [N-1:0]      mont_result,
    input  logic              mont_done
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_TOMONT_ISS  = 4'd1,
        S_TOMONT_WAIT = 4'd2,
        S_SQ_ISS      = 4'd3,
        S_SQ_WAIT     = 4'd4,
        S_MUL_ISS     = 4'd5,
        S_MUL_WAIT    = 4'd6,
        S_NEXT        = 4'd7,
        S_FROM_ISS    = 4'd8,
        S_FROM_WAIT   = 4'd9,
        S_DONE        = 4'd10
    } state_t;

    localparam logic [EL_W-1:0]   E_BITS_L = EL_W'(E_BITS);
    localparam logic [N-1:0]      ONE_N    = {{(N-1){1'b0}}, 1'b1};
    localparam logic [E_BITS-1:0] ONE_E    = {{(E_BITS-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [EL_W-1:0]     i_q, i_d;
    logic                len_zero_q, len_zero_d;
    logic [E_BITS-1:0]   e_q, e_d;
    logic [N-1:0]        x_q, x_d;
    logic [N-1:0]        r2_q, r2_d;
    logic [N-1:0]        acc_q, acc_d;
    logic [N-1:0]        xt_q, xt_d;
    logic [N-1:0]        result_q, result_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                mont_start_q, mont_start_d;
    logic [N-1:0]        mont_a_q, mont_a_d;
    logic [N-1:0]        mont_b_q, mont_b_d;
    logic [N-1:0]        mont_m_q, mont_m_d;

    logic [EL_W-1:0]     e_len_clamp_s;
    logic [E_BITS-1:0]   e_mask_s;
    logic                e_bit_s;

    // Exponent length clamping and selection of the current exponent bit e[i].
    always_comb begin
        if (in_e_len > E_BITS_L) begin
            e_len_clamp_s = E_BITS_L;
        end else begin
            e_len_clamp_s = in_e_len;
        end
        e_mask_s = ONE_E << i_q;
        e_bit_s  = |(e_q & e_mask_s);
    end

    // Next-state and datapath update; each multiply is an ISSUE/WAIT state pair.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        len_zero_d   = len_zero_q;
        e_d          = e_q;
        x_d          = x_q;
        r2_d         = r2_q;
        acc_d        = acc_q;
        xt_d         = xt_q;
        result_d     = result_q;
        done_d       = 1'b0;
        busy_d       = busy_q;
        mont_start_d = 1'b0;
        mont_a_d     = mont_a_q;
        mont_b_d     = mont_b_q;
        mont_m_d     = mont_m_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d        = in_x;
                    e_d        = in_e;
                    r2_d       = in_r2_mod_m;
                    acc_d      = in_r_mod_m;
                    mont_m_d   = in_m;
                    busy_d     = 1'b1;
                    len_zero_d = (e_len_clamp_s == {EL_W{1'b0}});
                    // With e_len = 0 the index is never used; keep it at 0.
                    if (e_len_clamp_s == {EL_W{1'b0}}) begin
                        i_d = {EL_W{1'b0}};
                    end else begin
                        i_d = e_len_clamp_s - EL_W'(1);
                    end
                    state_d = S_TOMONT_ISS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TOMONT_ISS: begin
                mont_a_d     = x_q;
                mont_b_d     = r2_q;
                mont_start_d = 1'b1;
                state_d      = S_TOMONT_WAIT;
            end
            S_TOMONT_WAIT: begin
                if (mont_done) begin
                    xt_d = mont_result;
                    if (len_zero_q) begin
                        state_d = S_FROM_ISS;
                    end else begin
                        state_d = S_SQ_ISS;
                    end
                end else begin
                    state_d = S_TOMONT_WAIT;
                end
            end
            S_SQ_ISS: begin
                mont_a_d     = acc_q;
                mont_b_d     = acc_q;
                mont_start_d = 1'b1;
                state_d      = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                if (mont_done) begin
                    acc_d = mont_result;
                    if (e_bit_s) begin
                        state_d = S_MUL_ISS;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else begin
                    state_d = S_SQ_WAIT;
                end
            end
            S_MUL_ISS: begin
                mont_a_d     = acc_q;
                mont_b_d     = xt_q;
                mont_start_d = 1'b1;
                state_d      = S_MUL_WAIT;
            end
            S_MUL_WAIT: begin
                if (mont_done) begin
                    acc_d   = mont_result;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_MUL_WAIT;
                end
            end
            S_NEXT: begin
                // Decrement only when i != 0, so the index never wraps.
                if (i_q == {EL_W{1'b0}}) begin
                    state_d = S_FROM_ISS;
                end else begin
                    i_d     = i_q - EL_W'(1);
                    state_d = S_SQ_ISS;
                end
            end
            S_FROM_ISS: begin
                mont_a_d     = acc_q;
                mont_b_d     = ONE_N;
                mont_start_d = 1'b1;
                state_d      = S_FROM_WAIT;
            end
            S_FROM_WAIT: begin
                // Result, done and busy are registered on the same edge, so done
                // is visible during the DONE state.
                if (mont_done) begin
                    acc_d    = mont_result;
                    result_d = mont_result;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_FROM_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            i_q          <= {EL_W{1'b0}};
            len_zero_q   <= 1'b0;
            e_q          <= {E_BITS{1'b0}};
            x_q          <= {N{1'b0}};
            r2_q         <= {N{1'b0}};
            acc_q        <= {N{1'b0}};
            xt_q         <= {N{1'b0}};
            result_q     <= {N{1'b0}};
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            mont_start_q <= 1'b0;
            mont_a_q     <= {N{1'b0}};
            mont_b_q     <= {N{1'b0}};
            mont_m_q     <= {N{1'b0}};
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            len_zero_q   <= len_zero_d;
            e_q          <= e_d;
            x_q          <= x_d;
            r2_q         <= r2_d;
            acc_q        <= acc_d;
            xt_q         <= xt_d;
            result_q     <= result_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            mont_start_q <= mont_start_d;
            mont_a_q     <= mont_a_d;
            mont_b_q     <= mont_b_d;
            mont_m_q     <= mont_m_d;
        end
    end

    assign result     = result_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign mont_start = mont_start_q;
    assign mont_a     = mont_a_q;
    assign mont_b     = mont_b_q;
    assign mont_m     = mont_m_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb_modexp_ctrl
//   Directed bench for modexp_ctrl with N = E_BITS = 16, M = 241.
//   A behavioural Montgomery multiplier (a*b*R^-1 mod 241, R^-1 = 15 mod 241)
//   answers each mont_start after a fixed latency. Expected results and
//   multiply counts are hand-computed.
module tb_modexp_ctrl;

    localparam int N      = 16;
    localparam int E_BITS = 16;
    localparam int EL_W   = 5;
    localparam int LAT    = 3;
    localparam logic [15:0] M_VAL  = 16'h00F1;
    localparam logic [15:0] R_MOD  = 16'd225;
    localparam logic [15:0] R2_MOD = 16'd15;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      in_x = '0;
    logic [E_BITS-1:0] in_e = '0;
    logic [EL_W-1:0]   in_e_len = '0;
    logic [N-1:0]      in_m = M_VAL;
    logic [N-1:0]      in_r_mod_m = R_MOD;
    logic [N-1:0]      in_r2_mod_m = R2_MOD;
    logic [N-1:0]      result;
    logic              done;
    logic              busy;
    logic              mont_start;
    logic [N-1:0]      mont_a;
    logic [N-1:0]      mont_b;
    logic [N-1:0]      mont_m;
    logic [N-1:0]      mont_result;
    logic              mont_done;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          pulse_cnt = 0;
    logic [15:0] exp_held = 16'h0000;

    modexp_ctrl #(.N(N), .E_BITS(E_BITS), .EL_W(EL_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .in_x        (in_x),
        .in_e        (in_e),
        .in_e_len    (in_e_len),
        .in_m        (in_m),
        .in_r_mod_m  (in_r_mod_m),
        .in_r2_mod_m (in_r2_mod_m),
        .result      (result),
        .done        (done),
        .busy        (busy),
        .mont_start  (mont_start),
        .mont_a      (mont_a),
        .mont_b      (mont_b),
        .mont_m      (mont_m),
        .mont_result (mont_result),
        .mont_done   (mont_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mont_ref(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = (longint'(a) * longint'(b)) % 241;
        p = (p * 15) % 241;
        return 16'(p);
    endfunction

    // Behavioural multiplier: samples mont_start on the falling edge, answers LAT cycles later.
    initial begin
        logic [15:0] ca;
        logic [15:0] cb;
        int          cnt;
        bit          pend;
        ca = 16'h0000;
        cb = 16'h0000;
        cnt = 0;
        pend = 1'b0;
        mont_done = 1'b0;
        mont_result = 16'h0000;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pend = 1'b0;
                mont_done = 1'b0;
            end else if (mont_start) begin
                pend = 1'b1;
                cnt = LAT;
                ca = mont_a;
                cb = mont_b;
                pulse_cnt++;
                mont_done = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    check_eq("stable_a", {16'h0000, mont_a}, {16'h0000, ca});
                    check_eq("stable_b", {16'h0000, mont_b}, {16'h0000, cb});
                    check_eq("mont_m", {16'h0000, mont_m}, {16'h0000, M_VAL});
                    mont_result = mont_ref(ca, cb);
                    mont_done = 1'b1;
                    pend = 1'b0;
                end else begin
                    mont_done = 1'b0;
                end
            end else begin
                mont_done = 1'b0;
            end
        end
    end

    // Called on a falling edge: checks the held result, then issues a 1-cycle start.
    task automatic start_op(input logic [15:0] x, input logic [15:0] e, input logic [4:0] el);
        check_eq("result_held", {16'h0000, result}, {16'h0000, exp_held});
        in_x = x;
        in_e = e;
        in_e_len = el;
        pulse_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Waits (bounded) for done, checks result/pulse count, then one more cycle.
    // poke drives a start during the DONE cycle, which must be ignored.
    task automatic wait_done(input string tag, input logic [15:0] exp_res, input int exp_pulses, input bit poke);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check_eq({tag, "_timeout"}, {31'd0, done}, 32'd1);
        end else begin
            check_eq({tag, "_result"}, {16'h0000, result}, {16'h0000, exp_res});
            check_eq({tag, "_pulses"}, pulse_cnt, exp_pulses);
            check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            if (poke) begin
                in_x = 16'd9;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check_eq({tag, "_done_single"}, {31'd0, done}, 32'd0);
            check_eq({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
            check_eq({tag, "_result_kept"}, {16'h0000, result}, {16'h0000, exp_res});
            exp_held = exp_res;
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_result", {16'h0000, result}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mont_start", {31'd0, mont_start}, 32'd0);
        check_eq("rst_mont_a", {16'h0000, mont_a}, 32'd0);
        check_eq("rst_mont_m", {16'h0000, mont_m}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // 1: 3^5 mod 241 = 2
        start_op(16'd3, 16'h0005, 5'd3);
        wait_done("t1", 16'h0002, 7, 1'b0);
        // 2: Fermat, 7^240 mod 241 = 1
        start_op(16'd7, 16'h00F0, 5'd8);
        wait_done("t2", 16'h0001, 14, 1'b0);
        // 3: (-1)^2 = 1, then 0^5 = 0
        start_op(16'h00F0, 16'h0002, 5'd2);
        wait_done("t3a", 16'h0001, 5, 1'b0);
        start_op(16'd0, 16'h0005, 5'd3);
        wait_done("t3b", 16'h0000, 7, 1'b0);
        // 4: e_len = 0 gives 1; e_len = 20 clamps to 16
        start_op(16'h0055, 16'h1234, 5'd0);
        wait_done("t4a", 16'h0001, 2, 1'b0);
        start_op(16'd3, 16'h0005, 5'd20);
        wait_done("t4b", 16'h0002, 20, 1'b0);

        // 5: start mid-run ignored; start in DONE cycle ignored; start right after accepted
        start_op(16'd3, 16'h0005, 5'd3);
        repeat (4) @(negedge clk);
        in_x = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_x = 16'd3;
        check_eq("t5_busy_mid", {31'd0, busy}, 32'd1);
        wait_done("t5", 16'h0002, 7, 1'b1);
        start_op(16'd2, 16'h000A, 5'd4);
        wait_done("t5b", 16'h003C, 8, 1'b0);

        // 6: reset during a MUL step of the Fermat run
        start_op(16'd7, 16'h00F0, 5'd8);
        n = 0;
        while (pulse_cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reached_mul", {31'd0, (pulse_cnt >= 3)}, 32'd1);
        resetn = 1'b0;
        #1;
        check_eq("t6_rst_result", {16'h0000, result}, 32'd0);
        check_eq("t6_rst_done", {31'd0, done}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_rst_mont_start", {31'd0, mont_start}, 32'd0);
        check_eq("t6_rst_mont_a", {16'h0000, mont_a}, 32'd0);
        check_eq("t6_rst_mont_b", {16'h0000, mont_b}, 32'd0);
        check_eq("t6_rst_mont_m", {16'h0000, mont_m}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n++;
            end
        end
        check_eq("t6_no_done", n, 0);
        check_eq("t6_busy_after_rst", {31'd0, busy}, 32'd0);
        exp_held = 16'h0000;
        start_op(16'd3, 16'h0005, 5'd3);
        wait_done("t6b", 16'h0002, 7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
